stream_rr_arbiter: RTL and testbench

- Shares one downstream valid/ready stream sink, typically a fifo write port, between NUM_REQ upstream requesters.
- Arbitration is round-robin at packet granularity. Once a requester wins, it holds the sink until it transfers a beat with last=1.
- The output is a one-entry registered stage, which keeps the fifo-side timing clean while sustaining one beat per cycle.

---
 rtl/stream_rr_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
//   Shares one valid/ready sink, typically a fifo write port, between NUM_REQ
//   requesters. Arbitration is round-robin at packet granularity. A winner keeps
//   the sink until it transfers a beat with last=1. The output is a one-entry
//   registered stage that sustains one beat per cycle.
//
//   Optional build macro: STREAM_RR_ARBITER_ID_EN
//     When defined, adds data_out_id. It is registered with data_out and holds
//     the index of the requester that supplied the beat.
//
//   The reset input is named "reset" but is active-low. It asserts
//   asynchronously and releases synchronously.

module stream_rr_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  WIDTH   = 32,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ-1:0]       req_val,
    output logic [NUM_REQ-1:0]       req_rdy,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_out_last,
    output logic                     data_out_val,
    input  logic                     data_out_rdy,
`ifdef STREAM_RR_ARBITER_ID_EN
    output logic [IDX_W-1:0]         data_out_id,
`endif
    output logic                     busy
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Arbitration state
    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;

    // Output stage
    logic             out_val_q, out_val_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
`ifdef STREAM_RR_ARBITER_ID_EN
    logic [IDX_W-1:0] out_id_q, out_id_d;
`endif

    // Combinational helpers
    logic             space;
    logic             found;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    int               scan_idx;
    logic [IDX_W-1:0] sel;
    logic             sel_ok;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    // Successor index modulo NUM_REQ. It never produces an out-of-range value.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) >= NUM_REQ - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // The output stage can take a beat when it is empty or being drained this cycle.
    assign space = ~out_val_q | data_out_rdy;

    // Round-robin scan starting at rr_ptr: pick the first valid requester.
    // NOTE: every signal written in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            cand = IDX_W'(scan_idx);
            if (!found && req_val[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Grant: the owner while locked, otherwise the scan winner. Gated by space and reset.
    always_comb begin
        sel     = (state_q == LOCKED) ? owner_q : winner;
        sel_ok  = (state_q == LOCKED) | found;
        req_rdy = '0;
        if (reset && sel_ok && space) begin
            req_rdy[sel] = 1'b1;
        end
    end

    assign xfer     = req_val[sel] & req_rdy[sel];
    assign sel_data = req_data[int'(sel)*WIDTH +: WIDTH];
    assign sel_last = req_last[sel];

    // Packet lock FSM. The round-robin pointer moves only when a last beat completes.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (sel_last) begin
                        rr_ptr_d = next_idx(winner);
                    end else begin
                        state_d = LOCKED;
                        owner_d = winner;
                    end
                end
            end
            LOCKED: begin
                if (xfer && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_idx(owner_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stage: load on transfer, clear on drain without refill, otherwise hold.
    always_comb begin
        out_val_d  = out_val_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
`ifdef STREAM_RR_ARBITER_ID_EN
        out_id_d   = out_id_q;
`endif
        if (xfer) begin
            out_val_d  = 1'b1;
            out_data_d = sel_data;
            out_last_d = sel_last;
`ifdef STREAM_RR_ARBITER_ID_EN
            out_id_d   = sel;
`endif
        end else if (data_out_rdy) begin
            out_val_d = 1'b0;
        end
    end

    // Arbitration state register.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values and no ordering race exists between blocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    // Output stage register.
    // NOTE: data and last are reset as well as valid, so the sink sees all-zero
    // outputs out of reset. A packet abandoned by reset leaves nothing behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_val_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
`ifdef STREAM_RR_ARBITER_ID_EN
            out_id_q   <= '0;
`endif
        end else begin
            out_val_q  <= out_val_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
`ifdef STREAM_RR_ARBITER_ID_EN
            out_id_q   <= out_id_d;
`endif
        end
    end

    assign data_out      = out_data_q;
    assign data_out_last = out_last_q;
    assign data_out_val  = out_val_q;
    assign busy          = (state_q == LOCKED);
`ifdef STREAM_RR_ARBITER_ID_EN
    assign data_out_id   = out_id_q;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Testbench for stream_rr_arbiter. It uses two instances: NUM_REQ=4 for the
// main scenarios and NUM_REQ=3 for the pointer-wrap and source-id scenario.
// Expected beats are queued when stimulus is loaded. They are popped whenever
// the sink takes a beat.

module tb_stream_rr_arbiter;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;

    // NUM_REQ=4 instance
    logic [4*W-1:0] req_data;
    logic [3:0]     req_last, req_val, req_rdy;
    logic [W-1:0]   data_out;
    logic           data_out_last, data_out_val, data_out_rdy, busy;
`ifdef STREAM_RR_ARBITER_ID_EN
    logic [1:0]     data_out_id;
`endif

    // NUM_REQ=3 instance
    logic [3*W-1:0] r3_data;
    logic [2:0]     r3_last, r3_val, r3_rdy;
    logic [W-1:0]   o3_data;
    logic           o3_last, o3_val, o3_rdy, o3_busy;
`ifdef STREAM_RR_ARBITER_ID_EN
    logic [1:0]     o3_id;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [W:0]     src_q [4][$];   // per-requester beats {last, data}
    logic [W:0]     exp_q [$];      // expected sink order {last, data}
    logic [W+1:0]   exp3_q [$];     // expected {id, data} for the 3-way instance
    logic [3:0]     hold;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.NUM_REQ(4), .WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .data_out     (data_out),
        .data_out_last(data_out_last),
        .data_out_val (data_out_val),
        .data_out_rdy (data_out_rdy),
`ifdef STREAM_RR_ARBITER_ID_EN
        .data_out_id  (data_out_id),
`endif
        .busy         (busy)
    );

    stream_rr_arbiter #(.NUM_REQ(3), .WIDTH(W)) dut3 (
        .clk          (clk),
        .reset        (reset),
        .req_data     (r3_data),
        .req_last     (r3_last),
        .req_val      (r3_val),
        .req_rdy      (r3_rdy),
        .data_out     (o3_data),
        .data_out_last(o3_last),
        .data_out_val (o3_val),
        .data_out_rdy (o3_rdy),
`ifdef STREAM_RR_ARBITER_ID_EN
        .data_out_id  (o3_id),
`endif
        .busy         (o3_busy)
    );

    function automatic logic [W:0] beat(input logic last, input logic [W-1:0] d);
        return {last, d};
    endfunction

    // Present the head of each requester queue on the bus. hold[] forces a bubble.
    task automatic drive();
        logic [W:0] b;
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0) begin
                b                 = src_q[i][0];
                req_val[i]        = ~hold[i];
                req_data[i*W +: W] = b[W-1:0];
                req_last[i]       = b[W];
            end else begin
                req_val[i]        = 1'b0;
                req_data[i*W +: W] = '0;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    // One clock. At the falling edge, note accepts and score any beat the sink
    // takes. After the rising edge, retire accepted beats and present the next ones.
    task automatic step();
        logic [3:0] acc;
        logic [W:0] e;
        @(negedge clk);
        acc = req_val & req_rdy;
        if (data_out_val && data_out_rdy) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got beat %h last %b, expected no beat", data_out, data_out_last);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e[W-1:0] || data_out_last !== e[W])
                    $display("FAIL sb_beat: got %h last %b, expected %h last %b",
                             data_out, data_out_last, e[W-1:0], e[W]);
                else
                    n_pass++;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) void'(src_q[i].pop_front());
        end
        drive();
    endtask

    task automatic run_until_empty(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_timeout: %0d beats outstanding, expected 0", name, exp_q.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        data_out_rdy = 1'b1;
        hold         = '0;
        req_val = '0; req_last = '0; req_data = '0;
        r3_val  = '0; r3_last  = '0; r3_data  = '0;
        o3_rdy  = 1'b1;
        #3;
        n_checks++;
        if (data_out_val !== 1'b0 || req_rdy !== 4'b0000 || busy !== 1'b0 || data_out !== '0)
            $display("FAIL reset_hold: got val %b rdy %b busy %b data %h, expected 0 0000 0 0",
                     data_out_val, req_rdy, busy, data_out);
        else
            n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (data_out_val !== 1'b0 || req_rdy !== 4'b0000 || busy !== 1'b0)
                $display("FAIL reset_idle: got val %b rdy %b busy %b, expected 0 0000 0",
                         data_out_val, req_rdy, busy);
            else
                n_pass++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rr_single();
        int n;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) begin
                src_q[i].push_back(beat(1'b1, 32'hA0 + 32'(i)));
                exp_q.push_back(beat(1'b1, 32'hA0 + 32'(i)));
            end
        drive();
        #1;
        n_checks++;
        if (req_rdy !== 4'b0001 || data_out_val !== 1'b0)
            $display("FAIL rr_first_grant: got rdy %b val %b, expected 0001 0", req_rdy, data_out_val);
        else
            n_pass++;
        step();
        n_checks++;
        if (data_out_val !== 1'b1 || data_out !== 32'hA0)
            $display("FAIL rr_latency: got val %b data %h, expected 1 000000a0", data_out_val, data_out);
        else
            n_pass++;
        n = 1;
        while (exp_q.size() > 0 && n < 30) begin
            step();
            n++;
        end
        n_checks++;
        if (n != 9)
            $display("FAIL rr_throughput: got %0d cycles for 8 beats, expected 9", n);
        else
            n_pass++;
    endtask

    task automatic test_packet_lock();
        src_q[1].push_back(beat(1'b1, 32'hE1));
        exp_q.push_back(beat(1'b1, 32'hE1));
        drive();
        run_until_empty("lock_pre", 10);
        // rr_ptr is now 2; req 2 wins over req 0/1, then wrap past idle req 3 to 0.
        src_q[0].push_back(beat(1'b1, 32'hD0));
        src_q[1].push_back(beat(1'b1, 32'hD1));
        src_q[2].push_back(beat(1'b0, 32'hC0));
        src_q[2].push_back(beat(1'b0, 32'hC1));
        src_q[2].push_back(beat(1'b1, 32'hC2));
        exp_q.push_back(beat(1'b0, 32'hC0));
        exp_q.push_back(beat(1'b0, 32'hC1));
        exp_q.push_back(beat(1'b1, 32'hC2));
        exp_q.push_back(beat(1'b1, 32'hD0));
        exp_q.push_back(beat(1'b1, 32'hD1));
        drive();
        step();
        #1;
        n_checks++;
        if (busy !== 1'b1 || req_rdy !== 4'b0100)
            $display("FAIL lock_beat1: got busy %b rdy %b, expected 1 0100", busy, req_rdy);
        else
            n_pass++;
        step();
        #1;
        n_checks++;
        if (busy !== 1'b1)
            $display("FAIL lock_beat2: got busy %b, expected 1", busy);
        else
            n_pass++;
        step();
        #1;
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL lock_release: got busy %b, expected 0", busy);
        else
            n_pass++;
        run_until_empty("lock", 20);
    endtask

    task automatic test_bubble();
        // rr_ptr is 2; req 1 is the only valid requester at first.
        src_q[1].push_back(beat(1'b0, 32'hF0));
        src_q[1].push_back(beat(1'b0, 32'hF1));
        src_q[1].push_back(beat(1'b1, 32'hF2));
        exp_q.push_back(beat(1'b0, 32'hF0));
        exp_q.push_back(beat(1'b0, 32'hF1));
        exp_q.push_back(beat(1'b1, 32'hF2));
        exp_q.push_back(beat(1'b1, 32'h60));
        drive();
        step();
        src_q[0].push_back(beat(1'b1, 32'h60));
        hold[1] = 1'b1;
        drive();
        repeat (2) begin
            step();
            #1;
            n_checks++;
            if (req_rdy !== 4'b0010 || busy !== 1'b1)
                $display("FAIL bubble_hold: got rdy %b busy %b, expected 0010 1", req_rdy, busy);
            else
                n_pass++;
        end
        hold[1] = 1'b0;
        drive();
        run_until_empty("bubble", 20);
    endtask

    task automatic test_backpressure();
        // rr_ptr is 1 after req 0's single beat.
        src_q[1].push_back(beat(1'b0, 32'h1234_0001));
        src_q[1].push_back(beat(1'b1, 32'h1234_0002));
        exp_q.push_back(beat(1'b0, 32'h1234_0001));
        exp_q.push_back(beat(1'b1, 32'h1234_0002));
        drive();
        step();
        data_out_rdy = 1'b0;
        repeat (4) begin
            step();
            #1;
            n_checks++;
            if (data_out !== 32'h1234_0001 || data_out_last !== 1'b0 ||
                data_out_val !== 1'b1 || req_rdy !== 4'b0000)
                $display("FAIL bp_stall: got data %h last %b val %b rdy %b, expected 12340001 0 1 0000",
                         data_out, data_out_last, data_out_val, req_rdy);
            else
                n_pass++;
        end
        data_out_rdy = 1'b1;
        step();
        #1;
        n_checks++;
        if (data_out_val !== 1'b1 || data_out !== 32'h1234_0002 || data_out_last !== 1'b1)
            $display("FAIL bp_drain_fill: got val %b data %h last %b, expected 1 12340002 1",
                     data_out_val, data_out, data_out_last);
        else
            n_pass++;
        run_until_empty("bp", 10);
    endtask

    task automatic test_reset_mid();
        // rr_ptr is 2; req 3 starts a packet that reset abandons.
        data_out_rdy = 1'b0;
        src_q[3].push_back(beat(1'b0, 32'hBAD0));
        src_q[3].push_back(beat(1'b0, 32'hBAD1));
        src_q[3].push_back(beat(1'b1, 32'hBAD2));
        drive();
        step();
        #1;
        n_checks++;
        if (busy !== 1'b1 || data_out_val !== 1'b1)
            $display("FAIL rstmid_pre: got busy %b val %b, expected 1 1", busy, data_out_val);
        else
            n_pass++;
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (data_out_val !== 1'b0 || busy !== 1'b0 || req_rdy !== 4'b0000 ||
            data_out !== '0 || data_out_last !== 1'b0)
            $display("FAIL rstmid_async: got val %b busy %b rdy %b data %h last %b, expected 0 0 0000 0 0",
                     data_out_val, busy, req_rdy, data_out, data_out_last);
        else
            n_pass++;
        for (int i = 0; i < 4; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        data_out_rdy = 1'b1;
        src_q[0].push_back(beat(1'b1, 32'h4B00));
        src_q[3].push_back(beat(1'b1, 32'h4B03));
        exp_q.push_back(beat(1'b1, 32'h4B00));
        exp_q.push_back(beat(1'b1, 32'h4B03));
        drive();
        #1;
        n_checks++;
        if (req_rdy !== 4'b0001 || busy !== 1'b0)
            $display("FAIL rstmid_regrant: got rdy %b busy %b, expected 0001 0", req_rdy, busy);
        else
            n_pass++;
        run_until_empty("rstmid", 10);
    endtask

    task automatic test_id3();
        logic [W+1:0] e;
        int n;
        for (int r = 0; r < 7; r++)
            exp3_q.push_back({2'(r % 3), 32'hB0 + 32'(r % 3)});
        r3_data = {32'hB2, 32'hB1, 32'hB0};
        r3_last = 3'b111;
        r3_val  = 3'b111;
        n = 0;
        while (exp3_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (o3_val) begin
                e = exp3_q.pop_front();
                n_checks++;
                if (o3_data !== e[W-1:0])
                    $display("FAIL id3_data: got %h, expected %h", o3_data, e[W-1:0]);
                else
                    n_pass++;
`ifdef STREAM_RR_ARBITER_ID_EN
                n_checks++;
                if (o3_id !== e[W+1:W])
                    $display("FAIL id3_id: got %0d, expected %0d", o3_id, e[W+1:W]);
                else
                    n_pass++;
`endif
            end
        end
        r3_val = '0;
        n_checks++;
        if (exp3_q.size() != 0)
            $display("FAIL id3_timeout: %0d beats outstanding, expected 0", exp3_q.size());
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_rr_single();
        test_packet_lock();
        test_bubble();
        test_backpressure();
        test_reset_mid();
        test_id3();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
